commit_wb_scheduler: RTL and testbench
======================================

// Module: commit_wb_scheduler
// PURPOSE
//  Sits between the dual-commit ROB and the single RegFile write port. Buffers up to
//  2 commits/cycle in a FIFO and drains one per cycle into RegFile. Forwards buffered
//  values to the dispatcher so operands stay correct while writes are pending.
//  Keeps buffered writes alive across mispredict, because committed state is architectural.
// PARAMETERS
//  DEPTH     4   FIFO entries (power of 2, >=2)
//  DATA_W    32  register value width
//  ROB_ID_W  5   ROB tag width (`ROB_ID_TYPE)
//  REG_W     6   extended reg index (`EX_REG_NUMBER_WIDTH); value 32 = "no rd"
// PORTS
//  clk           in  1        clock, posedge
//  rst           in  1        asynchronous, active-low reset
//  rdy           in  1        global enable; low = freeze
//  mispredict    in  1        ROB flush pulse
//  c0_valid      in  1        older commit valid
//  c0_rd/c0_id/c0_v  in  REG_W/ROB_ID_W/DATA_W   older commit rd, tag, value
//  c1_valid      in  1        younger commit valid
//  c1_rd/c1_id/c1_v  in  REG_W/ROB_ID_W/DATA_W   younger commit rd, tag, value
//  ready_to_rob  out 1        ROB may present commits this cycle
//  wb_en         out 1        RegFile write enable
//  wb_rd/wb_Q/wb_V   out REG_W/ROB_ID_W/DATA_W   RegFile write rd, tag, value
//  rs1/rs2       in  REG_W    dispatcher source indices
//  Qj_reg/Qk_reg in  ROB_ID_W tags returned by RegFile for rs1/rs2
//  Qj_out/Qk_out out ROB_ID_W corrected tags to dispatcher
//  Vj_fwd/Vk_fwd out DATA_W   forwarded value, valid when Q*_out == `NON_DEPENDENT
//  hit_j/hit_k   out 1        a forward occurred
// BEHAVIOUR
//  - Reset (rst=0, async): head=tail=count=0; all flush tags 0. wb_en=0. ready_to_rob=0
//    while rst is asserted, 1 after rst deasserts.
//  - Entry fields: {rd, id, v, post_flush}.
//  - Enqueue when rdy && ready_to_rob. Commits with rd==0 or rd==32 are dropped but
//    still accepted. c0 is enqueued before c1. c1 alone enqueues as a single entry.
//  - ready_to_rob = rdy && (DEPTH-count >= 2). Uses registered count, not this cycle's drain.
//  - Commit valid while !ready_to_rob: ignored; bench flags an error.
//  - Drain: wb_en = rdy && count!=0. wb_* is driven combinationally from head.
//    Head pops at clk edge when wb_en. A commit accepted in cycle N is written no
//    earlier than cycle N+1.
//  - Same-cycle enqueue 2 + drain 1: count += 1. FIFO full with drain: next-cycle
//    ready depends on the new count. Pointers wrap mod DEPTH.
//  - mispredict: does not discard entries. Sets post_flush=1 on all valid entries and
//    on entries enqueued in the same cycle. Draining continues normally.
//  - Forwarding, per source (rs1 shown):
//    - If rs1==0 or rs1==32: pass through (Qj_out=Qj_reg, Vj_fwd=0, hit_j=0).
//    - Q' = `NON_DEPENDENT if mispredict, else Qj_reg.
//    - Candidates, priority youngest first: c1 (if valid & accepted), then c0,
//      then FIFO tail-1 .. head.
//    - Match: rd==rs1 && (id==Q' || ((post_flush || mispredict) && Q'==`NON_DEPENDENT)).
//    - On match: hit_j=1, Qj_out=`NON_DEPENDENT, Vj_fwd=matched v.
//    - No match: Qj_out=Q', hit_j=0, Vj_fwd=0.
//      The dispatcher then uses the RegFile V when Q is `NON_DEPENDENT.
//  - rdy=0: no enqueue, no pop, wb_en=0. Forwarding stays combinational and valid.
//  - Reset mid-operation: buffered entries are lost; no write is issued.
// STRUCTURE
//  - Shared package/define.v: `NON_DEPENDENT, `REG_NUMBER (32), `ROB_ID_TYPE,
//    `EX_REG_NUMBER_WIDTH, `DATA_WIDTH.
//  - One sub-module: wb_fwd_match, a priority search over the FIFO and incoming commits.
//    Instantiated twice, for rs1 and rs2.
// TESTING
//  1. Reset, then c0={rd5,id3,0xAA} only -> wb_en=1 next cycle with rd5/id3/0xAA; count back to 0.
//  2. Two dual commits back-to-back into DEPTH=4 -> ready_to_rob=0 after the 2nd;
//     writes rd order c0,c1,c0,c1, one per cycle.
//  3. Buffered {rd7,id3,0x11}; rs1=7, Qj_reg=3 -> hit_j=1, Qj_out=NON_DEPENDENT,
//     Vj_fwd=0x11. Same case with Qj_reg=9 -> hit_j=0, Qj_out=9.
//  4. c0={rd4,id2,1}, c1={rd4,id6,2} same cycle; rs1=4, Qj_reg=6 -> Vj_fwd=2.
//     Writes: rd4=1, then rd4=2.
//  5. Three entries buffered; mispredict pulse; rs1 = buffered rd with Qj_reg=NON_DEPENDENT
//     -> hit on youngest match. All 3 writes still issued.
//  6. rdy=0 for 3 cycles with 2 entries -> wb_en=0 and count held. Async rst low
//     mid-drain -> wb_en=0 immediately, FIFO empty.

Source files
------------

// File: rtl/commit_wb_scheduler_pkg.sv
// Shared widths, entry layout and tag constants for the commit write-back scheduler.
// Pure definitions: no logic, no latency, no flow control.
package commit_wb_scheduler_pkg;

   localparam int DATA_W     = 32;
   localparam int ROB_ID_W   = 5;
   localparam int REG_W      = 6;
   localparam int REG_NUMBER = 32;

   // ROB tags start at 1, so tag 0 is free to mean "value already in RegFile".
   localparam logic [ROB_ID_W-1:0] NON_DEPENDENT = '0;

   typedef struct packed {
      logic [REG_W-1:0]    rd;
      logic [ROB_ID_W-1:0] id;
      logic [DATA_W-1:0]   v;
      logic                post_flush;
   } wb_ent_t;

   function automatic logic is_arch_rd(input logic [REG_W-1:0] r);
      return (r != '0) && (r != REG_W'(REG_NUMBER));
   endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first search of incoming commits and buffered writes for one source operand.
// Purely combinational, zero latency; no flow control of its own.
module wb_fwd_match
   import commit_wb_scheduler_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic [REG_W-1:0]    rs,
   input  logic [ROB_ID_W-1:0] q_reg,
   input  logic                mispredict,
   input  logic                c0_cand,
   input  wb_ent_t             c0_ent,
   input  logic                c1_cand,
   input  wb_ent_t             c1_ent,
   input  wb_ent_t             fifo_ent [DEPTH],
   input  logic [PTR_W-1:0]    head,
   input  logic [CNT_W-1:0]    count,
   output logic [ROB_ID_W-1:0] q_out,
   output logic [DATA_W-1:0]   v_fwd,
   output logic                hit
);

   logic [ROB_ID_W-1:0] q_eff;

   function automatic logic ent_match(input wb_ent_t e, input logic [REG_W-1:0] r,
                                      input logic [ROB_ID_W-1:0] q, input logic flush_now);
      return (e.rd == r) &&
             ((e.id == q) || ((e.post_flush || flush_now) && (q == NON_DEPENDENT)));
   endfunction

   // Scan oldest to youngest so the last hit (the youngest) wins.
   always_comb begin
      q_eff = mispredict ? NON_DEPENDENT : q_reg;
      hit   = 1'b0;
      v_fwd = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count) &&
             ent_match(fifo_ent[head + PTR_W'(i)], rs, q_eff, mispredict)) begin
            hit   = 1'b1;
            v_fwd = fifo_ent[head + PTR_W'(i)].v;
         end
      end
      if (c0_cand && ent_match(c0_ent, rs, q_eff, mispredict)) begin
         hit   = 1'b1;
         v_fwd = c0_ent.v;
      end
      if (c1_cand && ent_match(c1_ent, rs, q_eff, mispredict)) begin
         hit   = 1'b1;
         v_fwd = c1_ent.v;
      end
      q_out = hit ? NON_DEPENDENT : q_eff;
      if (!is_arch_rd(rs)) begin
         q_out = q_reg;
         v_fwd = '0;
         hit   = 1'b0;
      end
   end

endmodule

// File: rtl/commit_wb_scheduler.sv
// Buffers up to two ROB commits per cycle and drains one per cycle to the RegFile, forwarding pending values.
// Write issues the cycle after acceptance at the earliest; ROB is held off unless two free slots remain.
module commit_wb_scheduler
   import commit_wb_scheduler_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                mispredict,
   input  logic                c0_valid,
   input  logic [REG_W-1:0]    c0_rd,
   input  logic [ROB_ID_W-1:0] c0_id,
   input  logic [DATA_W-1:0]   c0_v,
   input  logic                c1_valid,
   input  logic [REG_W-1:0]    c1_rd,
   input  logic [ROB_ID_W-1:0] c1_id,
   input  logic [DATA_W-1:0]   c1_v,
   output logic                ready_to_rob,
   output logic                wb_en,
   output logic [REG_W-1:0]    wb_rd,
   output logic [ROB_ID_W-1:0] wb_Q,
   output logic [DATA_W-1:0]   wb_V,
   input  logic [REG_W-1:0]    rs1,
   input  logic [REG_W-1:0]    rs2,
   input  logic [ROB_ID_W-1:0] Qj_reg,
   input  logic [ROB_ID_W-1:0] Qk_reg,
   output logic [ROB_ID_W-1:0] Qj_out,
   output logic [ROB_ID_W-1:0] Qk_out,
   output logic [DATA_W-1:0]   Vj_fwd,
   output logic [DATA_W-1:0]   Vk_fwd,
   output logic                hit_j,
   output logic                hit_k
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   wb_ent_t          mem_q [DEPTH];
   wb_ent_t          mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, age;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push0, push1, c0_cand, c1_cand;
   wb_ent_t          c0_ent, c1_ent;

   // Gated on the registered count only, so a drain this cycle never widens the window.
   assign ready_to_rob = rst && rdy && (count_q <= CNT_W'(DEPTH - 2));
   assign c0_cand      = ready_to_rob && c0_valid;
   assign c1_cand      = ready_to_rob && c1_valid;
   assign push0        = c0_cand && is_arch_rd(c0_rd);
   assign push1        = c1_cand && is_arch_rd(c1_rd);
   assign c0_ent       = '{rd: c0_rd, id: c0_id, v: c0_v, post_flush: mispredict};
   assign c1_ent       = '{rd: c1_rd, id: c1_id, v: c1_v, post_flush: mispredict};

   assign wb_en = rdy && (count_q != '0);
   assign wb_rd = mem_q[head_q].rd;
   assign wb_Q  = mem_q[head_q].id;
   assign wb_V  = mem_q[head_q].v;

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      age     = '0;
      // Committed writes survive a flush; they are only tagged as post-flush.
      if (mispredict) begin
         for (int i = 0; i < DEPTH; i++) begin
            age = PTR_W'(i) - head_q;
            if (CNT_W'(age) < count_q) mem_d[i].post_flush = 1'b1;
         end
      end
      if (push0) begin
         mem_d[tail_d] = c0_ent;
         tail_d        = tail_d + 1'b1;
      end
      if (push1) begin
         mem_d[tail_d] = c1_ent;
         tail_d        = tail_d + 1'b1;
      end
      if (wb_en) head_d = head_q + 1'b1;
      count_d = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(wb_en);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_j (
      .rs(rs1), .q_reg(Qj_reg), .mispredict(mispredict),
      .c0_cand(c0_cand), .c0_ent(c0_ent), .c1_cand(c1_cand), .c1_ent(c1_ent),
      .fifo_ent(mem_q), .head(head_q), .count(count_q),
      .q_out(Qj_out), .v_fwd(Vj_fwd), .hit(hit_j)
   );

   wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_k (
      .rs(rs2), .q_reg(Qk_reg), .mispredict(mispredict),
      .c0_cand(c0_cand), .c0_ent(c0_ent), .c1_cand(c1_cand), .c1_ent(c1_ent),
      .fifo_ent(mem_q), .head(head_q), .count(count_q),
      .q_out(Qk_out), .v_fwd(Vk_fwd), .hit(hit_k)
   );

endmodule

// File: tb/tb_commit_wb_scheduler.sv
// Directed scenarios plus random traffic, checked against a queue-based model of the write buffer.
// Inputs change on the falling edge; outputs are sampled shortly after.
module tb_commit_wb_scheduler;
   import commit_wb_scheduler_pkg::*;

   localparam int TB_DEPTH = 4;

   typedef struct {
      logic [REG_W-1:0]    rd;
      logic [ROB_ID_W-1:0] id;
      logic [DATA_W-1:0]   v;
      logic                pf;
   } m_ent_t;

   logic clk = 1'b0;
   logic rst, rdy, mispredict;
   logic c0_valid, c1_valid;
   logic [REG_W-1:0]    c0_rd, c1_rd, rs1, rs2, wb_rd;
   logic [ROB_ID_W-1:0] c0_id, c1_id, Qj_reg, Qk_reg, wb_Q, Qj_out, Qk_out;
   logic [DATA_W-1:0]   c0_v, c1_v, wb_V, Vj_fwd, Vk_fwd;
   logic ready_to_rob, wb_en, hit_j, hit_k;

   m_ent_t mq[$];
   int n_chk, n_err;

   always #5 clk = ~clk;

   commit_wb_scheduler #(.DEPTH(TB_DEPTH)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .mispredict(mispredict),
      .c0_valid(c0_valid), .c0_rd(c0_rd), .c0_id(c0_id), .c0_v(c0_v),
      .c1_valid(c1_valid), .c1_rd(c1_rd), .c1_id(c1_id), .c1_v(c1_v),
      .ready_to_rob(ready_to_rob), .wb_en(wb_en), .wb_rd(wb_rd), .wb_Q(wb_Q), .wb_V(wb_V),
      .rs1(rs1), .rs2(rs2), .Qj_reg(Qj_reg), .Qk_reg(Qk_reg),
      .Qj_out(Qj_out), .Qk_out(Qk_out), .Vj_fwd(Vj_fwd), .Vk_fwd(Vk_fwd),
      .hit_j(hit_j), .hit_k(hit_k)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      c0_valid = 1'b0; c0_rd = '0; c0_id = '0; c0_v = '0;
      c1_valid = 1'b0; c1_rd = '0; c1_id = '0; c1_v = '0;
      mispredict = 1'b0;
      rs1 = '0; rs2 = '0; Qj_reg = '0; Qk_reg = '0;
   endtask

   function automatic logic [REG_W-1:0] pick_rd();
      int r;
      r = $urandom_range(0, 8);
      return (r == 8) ? REG_W'(32) : REG_W'(r);
   endfunction

   // Forwarding reference: newest candidate first, first rule hit wins.
   task automatic model_fwd(input logic [REG_W-1:0] rs, input logic [ROB_ID_W-1:0] qreg,
                            input logic acc, output logic [ROB_ID_W-1:0] qo,
                            output logic [DATA_W-1:0] vo, output logic h);
      m_ent_t cand[$];
      logic [ROB_ID_W-1:0] qe;
      qo = qreg; vo = '0; h = 1'b0;
      if (rs == 0 || rs == 32) return;
      qe = mispredict ? NON_DEPENDENT : qreg;
      qo = qe;
      if (acc && c1_valid) cand.push_back('{c1_rd, c1_id, c1_v, mispredict});
      if (acc && c0_valid) cand.push_back('{c0_rd, c0_id, c0_v, mispredict});
      for (int i = mq.size() - 1; i >= 0; i--) cand.push_back(mq[i]);
      foreach (cand[i]) begin
         if (!h && cand[i].rd == rs &&
             (cand[i].id == qe || ((cand[i].pf || mispredict) && qe == NON_DEPENDENT))) begin
            h = 1'b1; qo = NON_DEPENDENT; vo = cand[i].v;
         end
      end
   endtask

   // Check every output against the model, clock once, advance the model.
   task automatic step();
      logic acc, h;
      logic [ROB_ID_W-1:0] qo;
      logic [DATA_W-1:0] vo;
      #1;
      acc = rst && rdy && (TB_DEPTH - mq.size() >= 2);
      check_val("ready_to_rob", 64'(ready_to_rob), 64'(acc));
      if (c0_valid || c1_valid) check_val("commit_while_busy", 64'(ready_to_rob), 64'(1));
      check_val("wb_en", 64'(wb_en), 64'(rdy && (mq.size() > 0)));
      if (rdy && mq.size() > 0)
         check_val("wb_ent", 64'({wb_rd, wb_Q, wb_V}), 64'({mq[0].rd, mq[0].id, mq[0].v}));
      model_fwd(rs1, Qj_reg, acc, qo, vo, h);
      check_val("fwd_j", 64'({hit_j, Qj_out, Vj_fwd}), 64'({h, qo, vo}));
      model_fwd(rs2, Qk_reg, acc, qo, vo, h);
      check_val("fwd_k", 64'({hit_k, Qk_out, Vk_fwd}), 64'({h, qo, vo}));
      @(posedge clk);
      if (mispredict) foreach (mq[i]) mq[i].pf = 1'b1;
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (acc && c0_valid && c0_rd != 0 && c0_rd != 32) mq.push_back('{c0_rd, c0_id, c0_v, mispredict});
      if (acc && c1_valid && c1_rd != 0 && c1_rd != 32) mq.push_back('{c1_rd, c1_id, c1_v, mispredict});
      @(negedge clk);
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      rst = 1'b0; rdy = 1'b1; idle();
      repeat (2) @(negedge clk);
      check_val("rst_ready", 64'(ready_to_rob), 64'(0));
      check_val("rst_wb_en", 64'(wb_en), 64'(0));
      rst = 1'b1;
      #1 check_val("post_rst_ready", 64'(ready_to_rob), 64'(1));
      @(negedge clk);

      // single commit, written the following cycle
      c0_valid = 1'b1; c0_rd = 6'd5; c0_id = 5'd3; c0_v = 32'hAA;
      #1 check_val("t1_no_same_cycle_wb", 64'(wb_en), 64'(0));
      step(); idle();
      #1 check_val("t1_wb", 64'({wb_en, wb_rd, wb_Q, wb_V}), 64'({1'b1, 6'd5, 5'd3, 32'hAA}));
      step();
      #1 check_val("t1_empty", 64'(wb_en), 64'(0));
      step();

      // two dual commits back to back
      c0_valid = 1'b1; c0_rd = 6'd1; c0_id = 5'd1; c0_v = 32'd1;
      c1_valid = 1'b1; c1_rd = 6'd2; c1_id = 5'd2; c1_v = 32'd2;
      step();
      c0_rd = 6'd3; c0_id = 5'd3; c0_v = 32'd3;
      c1_rd = 6'd11; c1_id = 5'd4; c1_v = 32'd4;
      #1 check_val("t2_wb0", 64'(wb_rd), 64'(1));
      step(); idle();
      #1 check_val("t2_full_ready", 64'(ready_to_rob), 64'(0));
      check_val("t2_wb1", 64'(wb_rd), 64'(2));
      step();
      #1 check_val("t2_wb2", 64'(wb_rd), 64'(3));
      step();
      #1 check_val("t2_wb3", 64'(wb_rd), 64'(11));
      step();
      step();

      // forward from a buffered entry, frozen so it stays buffered
      c0_valid = 1'b1; c0_rd = 6'd7; c0_id = 5'd3; c0_v = 32'h11;
      step(); idle();
      rdy = 1'b0; rs1 = 6'd7; Qj_reg = 5'd3;
      #1 check_val("t3_hit", 64'({hit_j, Qj_out, Vj_fwd}), 64'({1'b1, NON_DEPENDENT, 32'h11}));
      Qj_reg = 5'd9;
      #1 check_val("t3_miss", 64'({hit_j, Qj_out, Vj_fwd}), 64'({1'b0, 5'd9, 32'h0}));
      step();
      rdy = 1'b1; rs1 = '0; Qj_reg = '0;
      step(); step();

      // same-cycle pair to the same rd: younger wins for forwarding, older written first
      c0_valid = 1'b1; c0_rd = 6'd4; c0_id = 5'd2; c0_v = 32'd1;
      c1_valid = 1'b1; c1_rd = 6'd4; c1_id = 5'd6; c1_v = 32'd2;
      rs1 = 6'd4; Qj_reg = 5'd6;
      #1 check_val("t4_fwd", 64'({hit_j, Qj_out, Vj_fwd}), 64'({1'b1, NON_DEPENDENT, 32'd2}));
      step(); idle();
      #1 check_val("t4_wb0", 64'({wb_rd, wb_V}), 64'({6'd4, 32'd1}));
      step();
      #1 check_val("t4_wb1", 64'({wb_rd, wb_V}), 64'({6'd4, 32'd2}));
      step();

      // mispredict with three buffered entries
      c0_valid = 1'b1; c0_rd = 6'd8; c0_id = 5'd1; c0_v = 32'h10;
      c1_valid = 1'b1; c1_rd = 6'd9; c1_id = 5'd2; c1_v = 32'h20;
      step();
      c0_rd = 6'd8; c0_id = 5'd3; c0_v = 32'h30;
      c1_rd = 6'd10; c1_id = 5'd4; c1_v = 32'h40;
      step(); idle();
      mispredict = 1'b1; rs1 = 6'd8; Qj_reg = NON_DEPENDENT; rs2 = 6'd10; Qk_reg = 5'd4;
      #1 check_val("t5_fwd_j", 64'({hit_j, Qj_out, Vj_fwd}), 64'({1'b1, NON_DEPENDENT, 32'h30}));
      check_val("t5_fwd_k", 64'({hit_k, Vk_fwd}), 64'({1'b1, 32'h40}));
      check_val("t5_wb0", 64'(wb_rd), 64'(9));
      step(); idle();
      rs1 = 6'd10; Qj_reg = NON_DEPENDENT;
      #1 check_val("t5_post_flush", 64'({hit_j, Vj_fwd}), 64'({1'b1, 32'h40}));
      check_val("t5_wb1", 64'(wb_rd), 64'(8));
      step(); idle();
      #1 check_val("t5_wb2", 64'(wb_rd), 64'(10));
      step();

      // freeze holds the buffer, then reset drops it mid-drain
      c0_valid = 1'b1; c0_rd = 6'd12; c0_id = 5'd5; c0_v = 32'h55;
      c1_valid = 1'b1; c1_rd = 6'd13; c1_id = 5'd6; c1_v = 32'h66;
      step(); idle();
      rdy = 1'b0;
      repeat (3) step();
      rdy = 1'b1;
      #1 check_val("t6_held", 64'({wb_en, wb_rd}), 64'({1'b1, 6'd12}));
      c0_valid = 1'b1; c0_rd = 6'd14; c0_id = 5'd7; c0_v = 32'h77;
      c1_valid = 1'b1; c1_rd = 6'd15; c1_id = 5'd1; c1_v = 32'h88;
      step(); idle();
      step();
      #2 rst = 1'b0;
      #1 check_val("t6_rst_wb_en", 64'(wb_en), 64'(0));
      check_val("t6_rst_ready", 64'(ready_to_rob), 64'(0));
      mq.delete();
      @(negedge clk);
      rst = 1'b1;
      step();

      // random traffic
      repeat (400) begin
         logic acc;
         rdy = ($urandom_range(0, 7) != 0);
         acc = rdy && (TB_DEPTH - mq.size() >= 2);
         c0_valid = acc && ($urandom_range(0, 2) != 0);
         c1_valid = acc && ($urandom_range(0, 2) != 0);
         c0_rd = pick_rd(); c0_id = ROB_ID_W'($urandom_range(1, 7)); c0_v = $urandom;
         c1_rd = pick_rd(); c1_id = ROB_ID_W'($urandom_range(1, 7)); c1_v = $urandom;
         mispredict = ($urandom_range(0, 9) == 0);
         rs1 = pick_rd(); Qj_reg = ROB_ID_W'($urandom_range(0, 7));
         rs2 = pick_rd(); Qk_reg = ROB_ID_W'($urandom_range(0, 7));
         step();
      end
      idle(); rdy = 1'b1;
      repeat (6) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
